// File: rtl/dual_edge_rate_meter.sv
// Edge-rate meter: unwraps a 4-bit wrapping edge count into per-window totals
// and posts one snapshot per window (or flushed partial window) to a valid/ready sink.
module dual_edge_rate_meter #(
   parameter int ACC_W = 16,
   parameter int WIN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIN_W-1:0] win_len,
   input  logic [3:0]       cnt_in,
   output logic [ACC_W-1:0] snap_data,
   output logic             snap_partial,
   output logic             snap_valid,
   input  logic             snap_ready,
   output logic [7:0]       drop_cnt,
   output logic             busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] COUNT = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;

   localparam logic [WIN_W-1:0] WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};

   logic [1:0]       state;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_next;
   logic [WIN_W-1:0] win_cnt;
   logic [3:0]       cnt_prev;
   logic [3:0]       delta;
   logic [ACC_W:0]   sum;
   logic             post;
   logic [ACC_W-1:0] post_data;
   logic             post_partial;

   // Modulo-16 difference unwraps the counter: 14 -> 0 gives 2.
   assign delta    = cnt_in - cnt_prev;
   assign sum      = {1'b0, acc} + {{(ACC_W-3){1'b0}}, delta};
   assign acc_next = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
   assign busy     = (state != IDLE);

   always_comb begin
      post         = 1'b0;
      post_data    = acc;
      post_partial = 1'b0;
      if (state == COUNT && en && win_cnt == '0) begin
         post      = 1'b1;
         post_data = acc_next;
      end else if (state == FLUSH) begin
         post         = 1'b1;
         post_partial = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         acc      <= '0;
         win_cnt  <= '0;
         cnt_prev <= '0;
      end else begin
         cnt_prev <= cnt_in;
         case (state)
            IDLE: begin
               acc <= '0;
               if (en) begin
                  state   <= COUNT;
                  win_cnt <= win_len;
               end
            end
            COUNT: begin
               if (en) begin
                  if (win_cnt != '0) begin
                     acc     <= acc_next;
                     win_cnt <= win_cnt - WIN_ONE;
                  end else begin
                     acc     <= '0;
                     win_cnt <= win_len;
                  end
               end else begin
                  state <= FLUSH;
               end
            end
            FLUSH: begin
               acc   <= '0;
               state <= IDLE;
            end
            default: begin
               acc   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   // A held, unaccepted snapshot wins; the newcomer is dropped and counted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_data    <= '0;
         snap_partial <= 1'b0;
         snap_valid   <= 1'b0;
         drop_cnt     <= '0;
      end else if (post) begin
         if (!snap_valid || snap_ready) begin
            snap_data    <= post_data;
            snap_partial <= post_partial;
            snap_valid   <= 1'b1;
         end else if (drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end else if (snap_valid && snap_ready) begin
         snap_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dual_edge_rate_meter.sv
// Directed bench for dual_edge_rate_meter: one task per scenario, inline checks.
module tb_dual_edge_rate_meter;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        en4;
   logic [7:0]  win_len;
   logic [3:0]  cnt_in;
   logic        snap_ready;
   logic [15:0] snap_data;
   logic        snap_partial;
   logic        snap_valid;
   logic [7:0]  drop_cnt;
   logic        busy;
   logic [3:0]  snap_data4;
   logic        snap_partial4;
   logic        snap_valid4;
   logic [7:0]  drop_cnt4;
   logic        busy4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dual_edge_rate_meter #(.ACC_W(16), .WIN_W(8)) dut (
      .clk(clk), .rst(rst), .en(en), .win_len(win_len), .cnt_in(cnt_in),
      .snap_data(snap_data), .snap_partial(snap_partial), .snap_valid(snap_valid),
      .snap_ready(snap_ready), .drop_cnt(drop_cnt), .busy(busy)
   );

   // Narrow accumulator instance used only for the saturation scenario.
   dual_edge_rate_meter #(.ACC_W(4), .WIN_W(8)) dut4 (
      .clk(clk), .rst(rst), .en(en4), .win_len(win_len), .cnt_in(cnt_in),
      .snap_data(snap_data4), .snap_partial(snap_partial4), .snap_valid(snap_valid4),
      .snap_ready(snap_ready), .drop_cnt(drop_cnt4), .busy(busy4)
   );

   task automatic tick(input logic [3:0] inc);
      cnt_in = cnt_in + inc;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      en = 1'b0;
      snap_ready = 1'b1;
      repeat (4) tick(4'd0);
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; en4 = 1'b0; win_len = 8'd0; cnt_in = 4'd0; snap_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (snap_data !== 16'd0) begin bad++; $display("FAIL reset_data got=%0d exp=0", snap_data); end
      total++; if (snap_partial !== 1'b0) begin bad++; $display("FAIL reset_partial got=%b exp=0", snap_partial); end
      total++; if (snap_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", snap_valid); end
      total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      rst = 1'b0;
      tick(4'd0);
      $display("test_reset done");
   endtask

   task automatic test_basic_rate();
      logic exp_v;
      win_len = 8'd3; snap_ready = 1'b1; en = 1'b1;
      tick(4'd2);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy); end
      for (int i = 0; i < 12; i++) begin
         tick(4'd2);
         exp_v = ((i % 4) == 3);
         total++; if (snap_valid !== exp_v) begin bad++; $display("FAIL basic_valid[%0d] got=%b exp=%b", i, snap_valid, exp_v); end
         if (exp_v) begin
            total++; if (snap_data !== 16'd8) begin bad++; $display("FAIL basic_data[%0d] got=%0d exp=8", i, snap_data); end
            total++; if (snap_partial !== 1'b0) begin bad++; $display("FAIL basic_partial[%0d] got=%b exp=0", i, snap_partial); end
            $display("basic window snapshot data=%0d", snap_data);
         end
      end
      total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL basic_drop got=%0d exp=0", drop_cnt); end
      drain();
   endtask

   task automatic test_win_len_zero();
      logic [3:0] incs [3];
      incs[0] = 4'd3; incs[1] = 4'd5; incs[2] = 4'd7;
      win_len = 8'd0; snap_ready = 1'b1; en = 1'b1;
      tick(4'd1);
      for (int i = 0; i < 3; i++) begin
         tick(incs[i]);
         total++; if (snap_valid !== 1'b1) begin bad++; $display("FAIL wl0_valid[%0d] got=%b exp=1", i, snap_valid); end
         total++; if (snap_data !== {12'd0, incs[i]}) begin bad++; $display("FAIL wl0_data[%0d] got=%0d exp=%0d", i, snap_data, incs[i]); end
         $display("win_len=0 snapshot data=%0d", snap_data);
      end
      drain();
   endtask

   task automatic test_wrap();
      win_len = 8'd3; snap_ready = 1'b1;
      cnt_in = 4'd10; en = 1'b1;
      tick(4'd0);
      repeat (4) tick(4'd2);
      total++; if (snap_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%b exp=1", snap_valid); end
      total++; if (snap_data !== 16'd8) begin bad++; $display("FAIL wrap_data got=%0d exp=8", snap_data); end
      $display("wrap snapshot data=%0d", snap_data);
      drain();
   endtask

   task automatic test_backpressure();
      win_len = 8'd1; snap_ready = 1'b0; en = 1'b1;
      tick(4'd1);
      tick(4'd1); tick(4'd1);
      total++; if (snap_valid !== 1'b1 || snap_data !== 16'd2) begin bad++; $display("FAIL bp_first got=%b/%0d exp=1/2", snap_valid, snap_data); end
      tick(4'd2); tick(4'd2);
      tick(4'd3); tick(4'd3);
      total++; if (snap_data !== 16'd2) begin bad++; $display("FAIL bp_hold got=%0d exp=2", snap_data); end
      total++; if (snap_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b exp=1", snap_valid); end
      total++; if (drop_cnt !== 8'd2) begin bad++; $display("FAIL bp_drop got=%0d exp=2", drop_cnt); end
      snap_ready = 1'b1; tick(4'd4);
      total++; if (snap_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b exp=0", snap_valid); end
      snap_ready = 1'b0; tick(4'd4);
      total++; if (snap_valid !== 1'b1 || snap_data !== 16'd8) begin bad++; $display("FAIL bp_w4 got=%b/%0d exp=1/8", snap_valid, snap_data); end
      tick(4'd5);
      snap_ready = 1'b1; tick(4'd5);
      total++; if (snap_valid !== 1'b1 || snap_data !== 16'd10) begin bad++; $display("FAIL bp_same_cycle got=%b/%0d exp=1/10", snap_valid, snap_data); end
      total++; if (drop_cnt !== 8'd2) begin bad++; $display("FAIL bp_drop2 got=%0d exp=2", drop_cnt); end
      tick(4'd1);
      total++; if (snap_valid !== 1'b0) begin bad++; $display("FAIL bp_clear got=%b exp=0", snap_valid); end
      $display("backpressure drops=%0d", drop_cnt);
      drain();
   endtask

   task automatic test_flush();
      win_len = 8'd9; snap_ready = 1'b1; en = 1'b1;
      tick(4'd2);
      repeat (3) tick(4'd2);
      en = 1'b0;
      tick(4'd2);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_busy_ef got=%b exp=1", busy); end
      total++; if (snap_valid !== 1'b0) begin bad++; $display("FAIL flush_early got=%b exp=0", snap_valid); end
      tick(4'd2);
      total++; if (snap_valid !== 1'b1) begin bad++; $display("FAIL flush_valid got=%b exp=1", snap_valid); end
      total++; if (snap_data !== 16'd6) begin bad++; $display("FAIL flush_data got=%0d exp=6", snap_data); end
      total++; if (snap_partial !== 1'b1) begin bad++; $display("FAIL flush_partial got=%b exp=1", snap_partial); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", busy); end
      $display("flush snapshot data=%0d partial=%b", snap_data, snap_partial);
      drain();
   endtask

   task automatic test_saturation();
      win_len = 8'd15; snap_ready = 1'b1; en4 = 1'b1;
      tick(4'd2);
      for (int i = 0; i < 32; i++) begin
         tick(4'd2);
         if (i == 15 || i == 31) begin
            total++; if (snap_valid4 !== 1'b1 || snap_data4 !== 4'd15) begin bad++; $display("FAIL sat_data[%0d] got=%b/%0d exp=1/15", i, snap_valid4, snap_data4); end
            $display("saturation snapshot data=%0d", snap_data4);
         end else if (i == 16) begin
            total++; if (snap_valid4 !== 1'b0) begin bad++; $display("FAIL sat_gap got=%b exp=0", snap_valid4); end
         end
      end
      total++; if (drop_cnt4 !== 8'd0) begin bad++; $display("FAIL sat_drop got=%0d exp=0", drop_cnt4); end
      en4 = 1'b0;
      drain();
   endtask

   task automatic test_reset_mid();
      win_len = 8'd0; snap_ready = 1'b0; en = 1'b1;
      tick(4'd1);
      tick(4'd1);
      repeat (3) tick(4'd1);
      total++; if (drop_cnt !== 8'd5 || snap_valid !== 1'b1) begin bad++; $display("FAIL rm_pre got=%0d/%b exp=5/1", drop_cnt, snap_valid); end
      #2 rst = 1'b1;
      #1;
      total++; if (snap_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b exp=0", snap_valid); end
      total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL rm_drop got=%0d exp=0", drop_cnt); end
      total++; if (snap_data !== 16'd0) begin bad++; $display("FAIL rm_data got=%0d exp=0", snap_data); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", busy); end
      #2 rst = 1'b0;
      snap_ready = 1'b1;
      tick(4'd3);
      tick(4'd3);
      total++; if (snap_valid !== 1'b1 || snap_data !== 16'd3) begin bad++; $display("FAIL rm_after got=%b/%0d exp=1/3", snap_valid, snap_data); end
      $display("post-reset snapshot data=%0d", snap_data);
      drain();
   endtask

   initial begin
      test_reset();
      test_basic_rate();
      test_win_len_zero();
      test_wrap();
      test_backpressure();
      test_flush();
      test_saturation();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
